clk_div_tick_sel: RTL and testbench
===================================

Name: clk_div_tick_sel

Overview:
- Consumer stage for the clock divider's outputs (divby_2/4/8/16).
- All four divided signals are sampled as data in the `clk` domain; they are never used as clocks.
- Selects one divided signal and emits a single-cycle `tick` on each of its rising edges, plus a running tick count.
- Ratio changes use a req/ack handshake and take effect only at the divider wrap point, so no runt or double ticks occur.

Parameters:
- CNT_W, 8, width of tick_cnt; counter wraps modulo 2^CNT_W.

Ports:
- clk  input  1  system clock; the divider runs on the same clock.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  tick/count enable.
- divby_2  input  1  divider output, period 2 clk.
- divby_4  input  1  divider output, period 4 clk.
- divby_8  input  1  divider output, period 8 clk.
- divby_16  input  1  divider output, period 16 clk.
- sel  input  2  requested ratio: 0=div2, 1=div4, 2=div8, 3=div16.
- sel_req  input  1  single-cycle request to change ratio to `sel`.
- sel_ack  output  1  single-cycle pulse when the requested ratio becomes active.
- active_sel  output  2  ratio currently in use.
- busy  output  1  high while a request is pending (state WAIT).
- tick  output  1  registered single-cycle pulse per rising edge of the selected input.
- tick_cnt  output  CNT_W  number of ticks since reset, wrapping.

Behaviour:
- Reset (asynchronous, rst=1) clears:
  - tick=0, tick_cnt=0, sel_ack=0, busy=0, active_sel=0;
  - edge-history register=0, pending_sel=0, state=IDLE.
- Selected signal `s` is divby_2/4/8/16, chosen by active_sel.
- Edge history `s_q` is a register loaded with `s` every cycle.
- Tick generation:
  - tick <= en & s & ~s_q.
  - Latency: tick is high in the cycle after the first cycle in which `s` is sampled 1 after being 0.
  - tick is never high two consecutive cycles.
- Tick count:
  - tick_cnt increments by 1 in the same cycle tick is asserted (tick_cnt <= tick_cnt+1 when the next-state tick is 1).
  - Wraps (2^CNT_W)-1 -> 0 with no flag.
- en=0: tick forced 0, tick_cnt holds, s_q keeps sampling.
  - Raising en while `s` is already high produces no tick until the next true rising edge.
- Boundary: cycle in which {divby_16,divby_8,divby_4,divby_2}==4'b0000 (divider wrap point, once per 16 clk).
- FSM:
  - IDLE:
    - sel_req=1, sel==active_sel: sel_ack=1 next cycle, no change, stay IDLE.
    - sel_req=1, sel!=active_sel: pending_sel<=sel, busy<=1, go WAIT.
  - WAIT:
    - sel_req ignored; pending_sel is not updated.
    - On boundary: active_sel<=pending_sel, s_q<=0, busy<=0, sel_ack pulses 1 cycle (next cycle), go IDLE.
    - Ticks from the old ratio continue normally until the switch.
  - Boundary with sel_req in the same cycle while IDLE: request is only latched; the switch waits for the next boundary.
- Switch safety:
  - At the boundary every input is 0, so the first tick after a switch is the first full rising edge of the new ratio.
  - No tick is lost or duplicated across the switch.
- FSM and switching operate regardless of en.
- rst asserted mid-WAIT: pending request discarded; active_sel returns to 0 (div2).
- Inputs are assumed glitch-free and synchronous to `clk`; no synchronizers are included.

Test Plan:
1. Reset then en=1, active_sel=0, divider free-running: tick pulses every 2 clk; after 20 clk tick_cnt=10 (±1 by phase); tick never high two cycles running.
2. sel_req with sel=3 mid-cycle: busy=1 until the next all-zero boundary; then active_sel=3, one-cycle sel_ack, busy=0; subsequent ticks every 16 clk; no extra tick at the switch.
3. sel_req with sel=0 while active_sel=0: sel_ack next cycle, busy stays 0, tick cadence unchanged.
4. During WAIT (pending sel=2), pulse sel_req with sel=1: ignored; the switch lands on active_sel=2.
5. en=0 for 10 clk at div4: tick=0, tick_cnt frozen; en=1 with divby_4 high: no tick until its next rising edge.
6. CNT_W=4, div2 for 40 clk: tick_cnt wraps 15->0. Separately, assert rst during WAIT: all outputs 0 immediately, active_sel=0, no sel_ack afterwards.

Source files
------------

// File: rtl/clk_div_tick_sel.sv
// Tick generator fed by the divider's divby_2/4/8/16 outputs, sampled as data.
// Ratio switches are deferred to the divider wrap point so no runt ticks occur.
module clk_div_tick_sel #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             divby_2,
    input  logic             divby_4,
    input  logic             divby_8,
    input  logic             divby_16,
    input  logic [1:0]       sel,
    input  logic             sel_req,
    output logic             sel_ack,
    output logic [1:0]       active_sel,
    output logic             busy,
    output logic             tick,
    output logic [CNT_W-1:0] tick_cnt
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         act_q, act_d;
    logic [1:0]         pend_q, pend_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic               s_q, s_d;
    logic               tick_q, tick_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               s;
    logic               boundary;

    always_comb begin
        s = 1'b0;
        unique case (act_q)
            2'd0: s = divby_2;
            2'd1: s = divby_4;
            2'd2: s = divby_8;
            2'd3: s = divby_16;
        endcase
    end

    // All divided outputs low at once only happens at the divider wrap
    assign boundary = ~|{divby_16, divby_8, divby_4, divby_2};

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        s_d     = s;
        tick_d  = en & s & ~s_q;
        cnt_d   = tick_d ? cnt_q + CNT_W'(1) : cnt_q;

        unique case (state_q)
            IDLE: begin
                if (sel_req) begin
                    if (sel == act_q) begin
                        ack_d = 1'b1;
                    end else begin
                        pend_d  = sel;
                        busy_d  = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (boundary) begin
                    act_d   = pend_q;
                    s_d     = 1'b0;
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            act_q   <= 2'd0;
            pend_q  <= 2'd0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            s_q     <= 1'b0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            s_q     <= s_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel_ack    = ack_q;
    assign active_sel = act_q;
    assign busy       = busy_q;
    assign tick       = tick_q;
    assign tick_cnt   = cnt_q;

endmodule

// File: tb/tb_clk_div_tick_sel.sv
// Bench for clk_div_tick_sel: directed table, random traffic against a model,
// two widths of tick counter driven from one free-running divider.
module tb_clk_div_tick_sel;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       sel_req = 1'b0;
    logic [3:0] dc = 4'd0;

    logic       ack8, busy8, tick8;
    logic [1:0] act8;
    logic [7:0] cnt8;
    logic       ack4, busy4, tick4;
    logic [1:0] act4;
    logic [3:0] cnt4;

    always #5 clk = ~clk;

    clk_div_tick_sel u_dut8 (
        .clk(clk), .rst(rst), .en(en),
        .divby_2(dc[0]), .divby_4(dc[1]),
        .divby_8(dc[2]), .divby_16(dc[3]),
        .sel(sel), .sel_req(sel_req),
        .sel_ack(ack8), .active_sel(act8),
        .busy(busy8), .tick(tick8), .tick_cnt(cnt8)
    );

    clk_div_tick_sel #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en),
        .divby_2(dc[0]), .divby_4(dc[1]),
        .divby_8(dc[2]), .divby_16(dc[3]),
        .sel(sel), .sel_req(sel_req),
        .sel_ack(ack4), .active_sel(act4),
        .busy(busy4), .tick(tick4), .tick_cnt(cnt4)
    );

    typedef struct {
        int n;
        bit en;
        bit req;
        int sel;
        bit busy;
        bit ack;
        int act;
        bit tick;
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_total = 0;

    // reference model state
    int m_act, m_pend, m_cnt;
    bit m_wait, e_tick, e_ack;
    bit prev_tick;

    function automatic vec_t mk(int n, bit e, bit r, int s,
                                bit b, bit a, int ac, bit t);
        vec_t v;
        v.n = n; v.en = e; v.req = r; v.sel = s;
        v.busy = b; v.ack = a; v.act = ac; v.tick = t;
        return v;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      name, got, exp, $time);
    endtask

    // Rising edge of divby_(2^(k+1)) is the count where c mod 2^(k+1) == 2^k
    task automatic model_edge();
        int c = int'(dc);
        e_tick = en && ((c % (2 << m_act)) == (1 << m_act));
        if (e_tick) m_cnt++;
        e_ack = 1'b0;
        if (!m_wait) begin
            if (sel_req) begin
                if (int'(sel) == m_act) e_ack = 1'b1;
                else begin
                    m_pend = int'(sel);
                    m_wait = 1'b1;
                end
            end
        end else if (c == 0) begin
            m_act  = m_pend;
            m_wait = 1'b0;
            e_ack  = 1'b1;
        end
    endtask

    task automatic cmp_model();
        chk("tick8", int'(tick8), int'(e_tick));
        chk("tick4", int'(tick4), int'(e_tick));
        chk("cnt8", int'(cnt8), m_cnt % 256);
        chk("cnt4", int'(cnt4), m_cnt % 16);
        chk("ack8", int'(ack8), int'(e_ack));
        chk("ack4", int'(ack4), int'(e_ack));
        chk("act8", int'(act8), m_act);
        chk("act4", int'(act4), m_act);
        chk("busy8", int'(busy8), int'(m_wait));
        chk("busy4", int'(busy4), int'(m_wait));
        chk("no_double", int'(tick8 & prev_tick), 0);
        prev_tick = tick8;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        dc = dc + 4'd1;
        cmp_model();
        sel_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_tick", int'(tick8 | tick4), 0);
        chk("rst_cnt8", int'(cnt8), 0);
        chk("rst_cnt4", int'(cnt4), 0);
        chk("rst_ack", int'(ack8 | ack4), 0);
        chk("rst_act", int'(act8 | act4), 0);
        chk("rst_busy", int'(busy8 | busy4), 0);
        dc = 4'd0;
        sel_req = 1'b0;
        m_act = 0; m_pend = 0; m_cnt = 0; m_wait = 1'b0;
        prev_tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tbl.push_back(mk(1,  1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1,  1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,  1, 1, 3, 1, 0, 0, 0));
        tbl.push_back(mk(1,  1, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(12, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1,  1, 0, 0, 0, 1, 3, 0));
        tbl.push_back(mk(8,  1, 0, 0, 0, 0, 3, 1));
        tbl.push_back(mk(1,  1, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(1,  1, 1, 2, 1, 0, 3, 0));
        tbl.push_back(mk(5,  1, 0, 0, 1, 0, 3, 0));
        tbl.push_back(mk(1,  1, 0, 0, 0, 1, 2, 0));
        tbl.push_back(mk(4,  1, 0, 0, 0, 0, 2, 1));
        tbl.push_back(mk(1,  1, 1, 1, 1, 0, 2, 0));
        tbl.push_back(mk(10, 1, 0, 0, 1, 0, 2, 0));
        tbl.push_back(mk(1,  1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1,  0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1,  0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1,  1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(3,  1, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(10, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(2,  1, 0, 0, 0, 0, 1, 1));

        #2;
        do_reset();

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                en = tbl[i].en;
                if (k == 0) begin
                    sel_req = tbl[i].req;
                    sel = 2'(tbl[i].sel);
                end
                step();
            end
            chk($sformatf("tbl%0d_busy", i), int'(busy8), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_ack", i), int'(ack8), int'(tbl[i].ack));
            chk($sformatf("tbl%0d_act", i), int'(act8), tbl[i].act);
            chk($sformatf("tbl%0d_tick", i), int'(tick8), int'(tbl[i].tick));
        end

        en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            sel_req = ($urandom_range(0, 11) == 0);
            sel = 2'($urandom_range(0, 3));
            step();
        end

        // drop a request mid-WAIT with an asynchronous reset
        en = 1'b1;
        while (m_wait) step();
        sel = 2'((m_act + 1) % 4);
        sel_req = 1'b1;
        step();
        chk("wait_busy", int'(busy8), 1);
        repeat (2) step();
        #2;
        do_reset();
        for (int i = 0; i < 40; i++) step();
        chk("after_rst_act", int'(act8), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
